// File: rtl/router_pkt_tx_if.sv
// Packet transmitter bus: packet request, payload source handshake and
// router-side byte stream. The master drives requests, payload and router
// back-pressure. The slave is the transmitter.
interface router_pkt_tx_if;
  logic       start;
  logic [1:0] addr;
  logic [5:0] len;
  logic [7:0] pay_data;
  logic       pay_valid;
  logic       pay_ready;
  logic       busy;
  logic       pkt_valid;
  logic [7:0] data_out;
  logic       out_valid;
  logic       tx_active;
  logic       tx_done;

  modport master (
    output start, addr, len, pay_data, pay_valid, busy,
    input  pay_ready, pkt_valid, data_out, out_valid, tx_active, tx_done
  );

  modport slave (
    input  start, addr, len, pay_data, pay_valid, busy,
    output pay_ready, pkt_valid, data_out, out_valid, tx_active, tx_done
  );
endinterface

// File: rtl/router_pkt_tx.sv
// Router packet transmitter. On a start request it sends one packet as a
// byte stream:
//   - a header byte {len, addr}
//   - len payload bytes taken from the source
//   - one parity byte, which is the XOR of the header and all payload bytes.
// A byte moves to the router on each posedge where out_valid=1 and busy=0.
// Optional feature, macro ERR_INJ_EN: adds a corrupt_parity input. It is
// captured with start, and when it is 1 the parity byte is sent inverted.
//
// state   | meaning
// IDLE    | waiting for start
// HEADER  | header byte on data_out
// PAYLOAD | payload byte on data_out, or starved waiting for the source
// PARITY  | parity byte on data_out (pkt_valid=0)
// DONE    | one-cycle tx_done pulse, then back to IDLE
module router_pkt_tx (
  input  logic               clock,
  input  logic               rst,
`ifdef ERR_INJ_EN
  input  logic               corrupt_parity,
`endif
  router_pkt_tx_if.slave     bus
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_HEADER  = 3'd1,
    S_PAYLOAD = 3'd2,
    S_PARITY  = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  state_t     r_state;
  logic [7:0] r_data_out;
  logic       r_out_valid;
  logic       r_pkt_valid;
  logic       r_tx_active;
  logic       r_tx_done;
  logic [5:0] r_remaining;
  logic [7:0] r_parity;
`ifdef ERR_INJ_EN
  logic       r_corrupt;
`endif

  logic       w_xfer;
  logic       w_pay_ready;
  logic       w_take;
  logic [7:0] w_parity_byte;

  // The current byte leaves when it is valid and the router is not busy.
  assign w_xfer = r_out_valid & ~bus.busy;

  // The next payload byte is pulled in the same cycle the current byte leaves
  // (or when the output is empty), so payload streams without bubbles.
  assign w_pay_ready = ((r_state == S_HEADER) || (r_state == S_PAYLOAD)) &&
                       (r_remaining != 6'd0) && (~r_out_valid | ~bus.busy);
  assign w_take      = w_pay_ready & bus.pay_valid;

`ifdef ERR_INJ_EN
  assign w_parity_byte = r_parity ^ {8{r_corrupt}};
`else
  assign w_parity_byte = r_parity;
`endif

  // Packet sequencing FSM with registered outputs.
  always_ff @(posedge clock) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_data_out  <= 8'h00;
      r_out_valid <= 1'b0;
      r_pkt_valid <= 1'b0;
      r_tx_active <= 1'b0;
      r_tx_done   <= 1'b0;
      r_remaining <= 6'd0;
      r_parity    <= 8'h00;
`ifdef ERR_INJ_EN
      r_corrupt   <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          r_tx_done <= 1'b0;
          if (bus.start) begin
            r_state     <= S_HEADER;
            r_data_out  <= {bus.len, bus.addr};
            r_parity    <= {bus.len, bus.addr};
            r_remaining <= bus.len;
            r_out_valid <= 1'b1;
            r_pkt_valid <= 1'b1;
            r_tx_active <= 1'b1;
`ifdef ERR_INJ_EN
            r_corrupt   <= corrupt_parity;
`endif
          end
        end

        // HEADER and PAYLOAD share the same logic. Each one either loads the
        // next payload byte, moves to parity once the count is exhausted, or
        // drops out_valid when the source starves (data_out keeps its value).
        S_HEADER, S_PAYLOAD: begin
          if (w_take) begin
            r_state     <= S_PAYLOAD;
            r_data_out  <= bus.pay_data;
            r_parity    <= r_parity ^ bus.pay_data;
            r_remaining <= r_remaining - 6'd1;
            r_out_valid <= 1'b1;
          end else if ((w_xfer || !r_out_valid) && (r_remaining == 6'd0)) begin
            r_state     <= S_PARITY;
            r_data_out  <= w_parity_byte;
            r_pkt_valid <= 1'b0;
            r_out_valid <= 1'b1;
          end else if (w_xfer) begin
            r_state     <= S_PAYLOAD;
            r_out_valid <= 1'b0;
          end
        end

        S_PARITY: begin
          if (w_xfer) begin
            r_state     <= S_DONE;
            r_out_valid <= 1'b0;
            r_tx_active <= 1'b0;
            r_tx_done   <= 1'b1;
          end
        end

        S_DONE: begin
          r_state   <= S_IDLE;
          r_tx_done <= 1'b0;
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.pay_ready = w_pay_ready;
  assign bus.pkt_valid = r_pkt_valid;
  assign bus.data_out  = r_data_out;
  assign bus.out_valid = r_out_valid;
  assign bus.tx_active = r_tx_active;
  assign bus.tx_done   = r_tx_done;

endmodule

// File: tb/tb_router_pkt_tx.sv
// Self-checking bench for router_pkt_tx. The driver pushes each expected
// byte to a scoreboard queue as soon as it requests a packet. Each byte the
// DUT shows is then compared against the head of that queue.
module tb_router_pkt_tx;

  logic clock = 1'b0;
  logic rst;
  always #5 clock = ~clock;

  router_pkt_tx_if bus();
`ifdef ERR_INJ_EN
  logic corrupt_parity;
`endif

  router_pkt_tx dut (
    .clock          (clock),
    .rst            (rst),
`ifdef ERR_INJ_EN
    .corrupt_parity (corrupt_parity),
`endif
    .bus            (bus)
  );

  int          n_checks = 0;
  int          n_errors = 0;
  logic [8:0]  sb_q[$];          // {pkt_valid, data}
  logic [7:0]  src_buf[64];

  typedef struct {
    logic [1:0]  addr;
    logic [5:0]  len;
    logic [31:0] pay;            // byte i at pay[8*i +: 8]
    logic [7:0]  hdr;
    logic [7:0]  par;
  } vec_t;
  vec_t tbl[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Sends one packet from src_buf. Callers can add options: stall the router
  // while byte stall_at is shown, starve the source before payload gap_at,
  // reset after abort_at bytes have moved, or keep start asserted
  // mid-packet as noise.
  task automatic run_pkt(input logic [1:0] a, input logic [5:0] l,
                         input logic [7:0] hdr, input logic [7:0] par,
                         input logic corrupt, input int stall_at, input int stall_n,
                         input int gap_at, input int gap_n, input int abort_at,
                         input bit noise);
    int n_out = 0, src_idx = 0, stall_left = stall_n, gap_left = gap_n;
    int byte_cyc = 0, starve = 0, bad_ready = 0, bad_active = 0, bad_starve = 0, cyc = 0;
    logic [7:0] last_byte = hdr;
    logic [8:0] exp;
    logic inv = 1'b0;
    bit done = 0, aborted = 0, abort_now = 0;
`ifdef ERR_INJ_EN
    inv = corrupt;
    corrupt_parity = corrupt;
`endif
    sb_q.push_back({1'b1, hdr});
    for (int i = 0; i < int'(l); i++) sb_q.push_back({1'b1, src_buf[i]});
    sb_q.push_back({1'b0, par ^ {8{inv}}});

    bus.start = 1'b1; bus.addr = a; bus.len = l; bus.busy = 1'b0;
    bus.pay_valid = (l != 6'd0); bus.pay_data = src_buf[0];
    @(posedge clock); #1;
    bus.start = noise;
    bus.addr  = ~a;
    bus.len   = l + 6'd5;
`ifdef ERR_INJ_EN
    corrupt_parity = ~corrupt;
`endif

    while (!done && cyc < 300) begin
      if (abort_now) begin
        rst = 1'b1; bus.pay_valid = 1'b0; bus.busy = 1'b0; bus.start = 1'b0;
        @(posedge clock); #1;
        rst = 1'b0;
        @(negedge clock);
        chk("reset_abort_outputs",
            {bus.pkt_valid, bus.out_valid, bus.data_out, bus.pay_ready, bus.tx_active, bus.tx_done}, 0);
        for (int k = 0; k < 3; k++) begin
          @(negedge clock);
          chk("no_parity_after_abort", bus.out_valid, 0);
        end
        sb_q.delete();
        aborted = 1;
        break;
      end
      bus.busy = (stall_left > 0) && (n_out == stall_at) && bus.out_valid;
      if (bus.busy) stall_left--;
      if (src_idx < int'(l)) begin
        if (src_idx == gap_at && gap_left > 0) begin
          bus.pay_valid = 1'b0; gap_left--;
        end else begin
          bus.pay_valid = 1'b1; bus.pay_data = src_buf[src_idx];
        end
      end else bus.pay_valid = 1'b0;

      @(negedge clock);
      cyc++;
      if (bus.tx_done) begin
        done = 1;
        bus.start = 1'b0; bus.pay_valid = 1'b0; bus.busy = 1'b0;
      end else begin
        byte_cyc++;
        if (!bus.tx_active) bad_active++;
        if (bus.pay_ready && src_idx >= int'(l)) bad_ready++;
        if (bus.busy && bus.pay_ready) bad_ready++;
        if (bus.out_valid) begin
          if (sb_q.size() == 0) chk("sb_underflow", sb_q.size(), 1);
          else begin
            exp = sb_q[0];
            chk("data_out", bus.data_out, exp[7:0]);
            chk("pkt_valid", bus.pkt_valid, exp[8]);
            if (!bus.busy) begin
              void'(sb_q.pop_front());
              last_byte = bus.data_out;
              n_out++;
            end
          end
        end else begin
          starve++;
          if (!bus.pkt_valid || bus.data_out !== last_byte) bad_starve++;
        end
        if (bus.pay_valid && bus.pay_ready) src_idx++;
        if (abort_at > 0 && n_out == abort_at) abort_now = 1;
        @(posedge clock); #1;
      end
    end

    if (!aborted) begin
      chk("tx_done_seen", done, 1);
      if (done) begin
        chk("done_outputs", {bus.tx_active, bus.out_valid, bus.pkt_valid}, 0);
        chk("sb_empty", sb_q.size(), 0);
        chk("bytes_out", n_out, int'(l) + 2);
        chk("duration", byte_cyc, int'(l) + 2 + stall_n + gap_n);
        chk("pay_ready_misuse", bad_ready, 0);
        chk("tx_active_gap", bad_active, 0);
        chk("starve_cycles", starve, gap_n);
        chk("starve_hold", bad_starve, 0);
      end
      sb_q.delete();
    end
  endtask

  task automatic load_311();
    src_buf[0] = 8'h11; src_buf[1] = 8'h22; src_buf[2] = 8'h33;
  endtask

  task automatic idle_check();
    @(posedge clock); #1;
    chk("tx_done_one_cycle", {bus.tx_done, bus.out_valid, bus.tx_active}, 0);
  endtask

  initial begin
    logic [7:0] p;
    tbl[0] = '{addr: 2'b01, len: 6'd3, pay: 32'h00332211, hdr: 8'h0D, par: 8'h0D};
    tbl[1] = '{addr: 2'b10, len: 6'd0, pay: 32'h00000000, hdr: 8'h02, par: 8'h02};
    tbl[2] = '{addr: 2'b11, len: 6'd2, pay: 32'h000055AA, hdr: 8'h0B, par: 8'hF4};
    tbl[3] = '{addr: 2'b00, len: 6'd4, pay: 32'h08040201, hdr: 8'h10, par: 8'h1F};
    tbl[4] = '{addr: 2'b01, len: 6'd1, pay: 32'h000000FF, hdr: 8'h05, par: 8'hFA};

    rst = 1'b1;
    bus.start = 1'b0; bus.addr = 2'b00; bus.len = 6'd0;
    bus.pay_data = 8'h00; bus.pay_valid = 1'b0; bus.busy = 1'b0;
`ifdef ERR_INJ_EN
    corrupt_parity = 1'b0;
`endif
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("reset_outputs",
        {bus.pkt_valid, bus.out_valid, bus.data_out, bus.pay_ready, bus.tx_active, bus.tx_done}, 0);
    @(posedge clock); #1;
    rst = 1'b0;

    // Table of packets, router always ready, source always valid.
    for (int t = 0; t < 5; t++) begin
      for (int i = 0; i < 4; i++) src_buf[i] = tbl[t].pay[8*i +: 8];
      run_pkt(tbl[t].addr, tbl[t].len, tbl[t].hdr, tbl[t].par, 1'b0, -1, 0, -1, 0, 0, 0);
      idle_check();
    end

    // Router busy for 2 cycles while 0x22 is shown.
    load_311();
    run_pkt(2'b01, 6'd3, 8'h0D, 8'h0D, 1'b0, 2, 2, -1, 0, 0, 0);
    idle_check();

    // Source starves for 2 cycles between 0x11 and 0x22.
    load_311();
    run_pkt(2'b01, 6'd3, 8'h0D, 8'h0D, 1'b0, -1, 0, 1, 2, 0, 0);
    idle_check();

    // Parity corruption. The expected byte is inverted only when the feature is built.
    load_311();
    run_pkt(2'b01, 6'd3, 8'h0D, 8'h0D, 1'b1, -1, 0, -1, 0, 0, 0);
    idle_check();

    // start held high mid-packet with changing addr/len; it must be ignored.
    for (int i = 0; i < 4; i++) src_buf[i] = tbl[3].pay[8*i +: 8];
    run_pkt(2'b00, 6'd4, 8'h10, 8'h1F, 1'b0, -1, 0, -1, 0, 0, 1);
    idle_check();

    // A start raised in the DONE cycle is ignored, then accepted from IDLE.
    load_311();
    run_pkt(2'b01, 6'd3, 8'h0D, 8'h0D, 1'b0, -1, 0, -1, 0, 0, 0);
    bus.start = 1'b1; bus.addr = 2'b10; bus.len = 6'd0;
    @(posedge clock); #1;
    chk("start_in_done_ignored", {bus.out_valid, bus.tx_active}, 0);
    run_pkt(2'b10, 6'd0, 8'h02, 8'h02, 1'b0, -1, 0, -1, 0, 0, 0);
    idle_check();

    // Reset after the second payload byte, then send a full packet.
    load_311();
    run_pkt(2'b01, 6'd3, 8'h0D, 8'h0D, 1'b0, -1, 0, -1, 0, 3, 0);
    load_311();
    run_pkt(2'b01, 6'd3, 8'h0D, 8'h0D, 1'b0, -1, 0, -1, 0, 0, 0);
    idle_check();

    // Maximum-length packet with random payload.
    p = 8'hFF;
    for (int i = 0; i < 63; i++) begin
      src_buf[i] = 8'($urandom_range(0, 255));
      p = p ^ src_buf[i];
    end
    run_pkt(2'b11, 6'd63, 8'hFF, p, 1'b0, -1, 0, -1, 0, 0, 0);
    idle_check();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
